// File: rtl/wb_ram_slave_if.sv
// Wishbone B3 classic link between one master and one slave.
// Widths follow the slave it is attached to.
interface if_wb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]   dat_m;
  logic [DATA_WIDTH-1:0]   dat_s;
  logic                    ack;
  logic                    err;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err
  );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B3 classic slave: byte-lane RAM with fixed wait states.
// Out-of-range word addresses terminate with ERR instead of ACK.
module wb_ram_slave #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 13,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic reset,
  if_wb.slave wb
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] L_DEPTH =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] L_WLOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic L_WS0 = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [NB-1:0]         r_sel;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] r_dat_s;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_req;
  logic                  w_idle;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_adr;
  logic                  w_oor;
  logic                  w_enter;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_rdat;

  assign w_req  = wb.cyc & wb.stb;
  assign w_idle = (r_state == S_IDLE);
  assign w_adr  = w_idle ? wb.adr : r_adr;
  assign w_we   = w_idle ? wb.we : r_we;
  assign w_oor  = {1'b0, w_adr} >= L_DEPTH;
  assign w_rdat = r_mem[w_adr[MAW-1:0]];

  // Last cycle before RESP: either IDLE with no wait states or WAIT at 0.
  assign w_enter = w_req &
    ((w_idle & L_WS0) |
     ((r_state == S_WAIT) & (r_cnt == 4'd0)));

  // r_ack is only set for in-range transfers, so it gates the commit.
  assign w_wr = (r_state == S_RESP) & r_we & r_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_dat_s <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we  <= wb.we;
            r_adr <= wb.adr;
            r_sel <= wb.sel;
            r_dat <= wb.dat_m;
            if (L_WS0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= L_WLOAD;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter) begin
        r_ack <= ~w_oor;
        r_err <= w_oor;
        if (!w_we && !w_oor) r_dat_s <= w_rdat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (r_sel[i]) begin
          r_mem[r_adr[MAW-1:0]][8*i +: 8] <= r_dat[8*i +: 8];
        end
      end
    end
  end

  assign wb.ack   = r_ack;
  assign wb.err   = r_err;
  assign wb.dat_s = r_dat_s;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (0, 1 and 3 wait states)
// share one master stimulus and are checked against a transfer model.
module tb_wb_ram_slave;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [12:0] adr   = '0;
  logic [1:0]  sel   = '0;
  logic [15:0] dat_m = '0;

  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [15:0] dats_v [3];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int t0    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    if_wb #(.DATA_WIDTH(16), .ADDR_WIDTH(13)) bus ();
    assign bus.cyc   = cyc;
    assign bus.stb   = stb;
    assign bus.we    = we;
    assign bus.adr   = adr;
    assign bus.sel   = sel;
    assign bus.dat_m = dat_m;
    assign ack_v[g]  = bus.ack;
    assign err_v[g]  = bus.err;
    assign dats_v[g] = bus.dat_s;
    wb_ram_slave #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (13),
      .DEPTH      (4096),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk  (clk),
      .reset(rst_n),
      .wb   (bus)
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [12:0] win_addr(input int i);
    if (i < 16) return 13'(i);
    case (i)
      16:      return 13'h0010;
      17:      return 13'h0020;
      18:      return 13'h0FFF;
      19:      return 13'h1000;
      default: return 13'h1FFF;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  // Transfer model: a request seen while free starts a transfer at
  // cycle s; it answers in cycle s+1+ws unless the request drops first.
  logic [15:0] mm [3][4096];
  bit          mbusy [3];
  int          ms    [3];
  logic        mwe   [3];
  logic [12:0] madr  [3];
  logic [1:0]  msel  [3];
  logic [15:0] mdat  [3];
  logic        eack  [3];
  logic        eerr  [3];
  logic [15:0] edat  [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mbusy[k] = 0;
        eack[k]  = 1'b0;
        eerr[k]  = 1'b0;
        edat[k]  = '0;
      end else if (mbusy[k] && cyc_n == ms[k] + 1 + ws_of(k)) begin
        if (mwe[k] && madr[k] < 13'h1000) begin
          for (int b = 0; b < 2; b++) begin
            if (msel[k][b])
              mm[k][madr[k][11:0]][8*b +: 8] = mdat[k][8*b +: 8];
          end
        end
        mbusy[k] = 0;
        eack[k]  = 1'b0;
        eerr[k]  = 1'b0;
      end else begin
        if (!mbusy[k] && cyc && stb) begin
          mbusy[k] = 1;
          ms[k]    = cyc_n;
          mwe[k]   = we;
          madr[k]  = adr;
          msel[k]  = sel;
          mdat[k]  = dat_m;
        end else if (mbusy[k] && !(cyc && stb)) begin
          mbusy[k] = 0;
        end
        if (mbusy[k] && cyc_n == ms[k] + ws_of(k)) begin
          eack[k] = (madr[k] < 13'h1000);
          eerr[k] = (madr[k] >= 13'h1000);
          if (!mwe[k] && madr[k] < 13'h1000)
            edat[k] = mm[k][madr[k][11:0]];
        end
      end
    end
    cyc_n++;
  end

  int          ack_n [3];
  int          err_n [3];
  int          ack_t [3][8];
  logic [15:0] ack_d [3][8];
  int          err_t [3][8];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ws%0d ack", ws_of(k)), 32'(ack_v[k]), 32'(eack[k]));
      check($sformatf("ws%0d err", ws_of(k)), 32'(err_v[k]), 32'(eerr[k]));
      check($sformatf("ws%0d dat_s", ws_of(k)), 32'(dats_v[k]),
            32'(edat[k]));
      if (ack_v[k] && ack_n[k] < 8) begin
        ack_t[k][ack_n[k]] = cyc_n;
        ack_d[k][ack_n[k]] = dats_v[k];
        ack_n[k]++;
      end
      if (err_v[k] && err_n[k] < 8) begin
        err_t[k][err_n[k]] = cyc_n;
        err_n[k]++;
      end
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) begin
      ack_n[k] = 0;
      err_n[k] = 0;
    end
    t0 = cyc_n;
  endtask

  // Called just after a rising edge; leaves the bus idle and settled.
  task automatic xfer(input logic w, input logic [12:0] a,
                      input logic [1:0] s, input logic [15:0] d,
                      input int hold, input bit keep_cyc);
    clear_logs();
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; sel = s; dat_m = d;
    repeat (hold) @(posedge clk);
    #1;
    stb = 1'b0;
    cyc = keep_cyc;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string nm, input logic [15:0] e0,
                          input logic [15:0] e1, input logic [15:0] e3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s ws%0d acked", nm, ws_of(k)),
            32'(ack_n[k] > 0), 32'd1);
      check($sformatf("%s ws%0d data", nm, ws_of(k)), 32'(ack_d[k][0]),
            32'((k == 0) ? e0 : ((k == 1) ? e1 : e3)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++)
      check($sformatf("reset dat_s ws%0d", ws_of(k)), 32'(dats_v[k]), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++)
      xfer(1'b1, win_addr(i), 2'b11, 16'(win_addr(i)) ^ 16'h5A5A, 5, 0);

    xfer(1'b1, 13'h0010, 2'b11, 16'hBEEF, 5, 0);
    xfer(1'b0, 13'h0010, 2'b11, 16'h0000, 5, 0);
    for (int k = 0; k < 3; k++)
      check($sformatf("read latency ws%0d", ws_of(k)),
            32'(ack_t[k][0] - t0), 32'(lat_of(k)));
    read_all("beef", 16'hBEEF, 16'hBEEF, 16'hBEEF);

    xfer(1'b1, 13'h0010, 2'b10, 16'h12AB, 5, 0);
    xfer(1'b0, 13'h0010, 2'b00, 16'h0000, 5, 0);
    read_all("lane hi", 16'h12EF, 16'h12EF, 16'h12EF);
    xfer(1'b1, 13'h0010, 2'b01, 16'hCD34, 5, 0);
    xfer(1'b0, 13'h0010, 2'b11, 16'h0000, 5, 0);
    read_all("lane lo", 16'h1234, 16'h1234, 16'h1234);

    xfer(1'b0, 13'h1000, 2'b11, 16'h0000, 5, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("oor ack ws%0d", ws_of(k)), 32'(ack_n[k]), 0);
      check($sformatf("oor err ws%0d", ws_of(k)),
            32'(err_n[k] > 0), 32'd1);
      check($sformatf("oor latency ws%0d", ws_of(k)),
            32'(err_t[k][0] - t0), 32'(lat_of(k)));
    end
    xfer(1'b1, 13'h1FFF, 2'b11, 16'hDEAD, 5, 0);
    xfer(1'b0, 13'h0FFF, 2'b11, 16'h0000, 5, 0);
    read_all("alias", 16'h55A5, 16'h55A5, 16'h55A5);

    xfer(1'b1, 13'h0020, 2'b11, 16'hAAAA, 3, 1);
    check("abort ws3 ack", 32'(ack_n[2]), 0);
    check("abort ws3 err", 32'(err_n[2]), 0);
    xfer(1'b0, 13'h0020, 2'b11, 16'h0000, 5, 0);
    read_all("abort", 16'hAAAA, 16'hAAAA, 16'h5A7A);

    clear_logs();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 13'h0000;
    repeat (2) @(posedge clk);
    #1;
    adr = 13'h0001;
    repeat (2) @(posedge clk);
    #1;
    adr = 13'h0002;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b count", 32'(ack_n[0]), 32'd3);
    check("b2b first", 32'(ack_t[0][0] - t0), 32'd1);
    check("b2b gap1", 32'(ack_t[0][1] - ack_t[0][0]), 32'd2);
    check("b2b gap2", 32'(ack_t[0][2] - ack_t[0][1]), 32'd2);
    check("b2b d0", 32'(ack_d[0][0]), 32'h5A5A);
    check("b2b d1", 32'(ack_d[0][1]), 32'h5A5B);
    check("b2b d2", 32'(ack_d[0][2]), 32'h5A58);

    clear_logs();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11;
    adr = 13'h0005; dat_m = 16'h7777;
    @(posedge clk);
    #1;
    adr = 13'h1000; dat_m = 16'hDEAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async rst ack ws%0d", ws_of(k)), 32'(ack_v[k]), 0);
      check($sformatf("async rst err ws%0d", ws_of(k)), 32'(err_v[k]), 0);
      check($sformatf("async rst dat ws%0d", ws_of(k)),
            32'(dats_v[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xfer(1'b0, 13'h0005, 2'b11, 16'h0000, 5, 0);
    read_all("rst drop", 16'h7777, 16'h7777, 16'h5A5F);

    repeat (300) begin
      cyc = 1'b1; stb = 1'b1;
      we = 1'($urandom_range(0, 1));
      adr = win_addr(int'($urandom_range(0, 20)));
      sel = 2'($urandom_range(0, 3));
      dat_m = 16'($urandom);
      repeat ($urandom_range(1, 6)) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 3) == 0) begin
          adr = win_addr(int'($urandom_range(0, 20)));
          dat_m = 16'($urandom);
          we = 1'($urandom_range(0, 1));
        end
      end
      stb = 1'b0;
      cyc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        cyc = 1'b0; stb = 1'b1;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
